// File: rtl/rvee_pcgen_fq_if.sv
// Fetch-address queue head interface between the PC generator and fetch.
// master: PC generator (drives valid/pc/epoch), slave: fetch unit (drives ready).
interface rvee_pcgen_fq_if #(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 2
);
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [EPOCH_W-1:0] out_epoch;

  modport master (output out_valid, output out_pc, output out_epoch, input  out_ready);
  modport slave  (input  out_valid, input  out_pc, input  out_epoch, output out_ready);
endinterface

// File: rtl/rvee_pcgen_fq.sv
// RVee PC generator with a DEPTH-entry fetch-address queue.
// Sequential PCs at STEP stride; EX jump/branch and trap redirects flush the
// queue and bump the epoch tag carried with every queued PC.
// Build option RVEE_PCGEN_RVC_EN: 2-byte target alignment, misalign never set.
// Without it targets align to 4 bytes and misalign pulses when target bit1 is set.
module rvee_pcgen_fq #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int STEP    = 4,
  parameter int EPOCH_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            resetv,
  input  logic                       jmp,
  input  logic [XLEN-1:0]            jmp_base,
  input  logic [XLEN-1:0]            jmp_offset,
  input  logic                       bcc,
  input  logic                       trap,
  input  logic [XLEN-1:0]            trap_vec,
  input  logic                       stall,
  rvee_pcgen_fq_if.master            fq,
  output logic                       redirect,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef RVEE_PCGEN_RVC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] ep;
  } ent_t;

  ent_t               mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               jmp_ff_q;
  logic [XLEN-1:0]    base_q, offset_q;
  logic               misalign_q, misalign_d;

  logic [XLEN-1:0]    tgt_raw;
  logic               br_take, push, pop;

  // Redirect target select: trap wins over the EX branch/jump.
  always_comb begin
    br_take     = jmp_ff_q | bcc;
    redirect    = trap | br_take;
    tgt_raw     = trap ? trap_vec : (base_q + offset_q);
    redirect_pc = tgt_raw & ALIGN_MASK;
  end

  assign fq.out_valid = (count_q != '0);
  assign fq.out_pc    = mem_q[rd_ptr_q].pc;
  assign fq.out_epoch = mem_q[rd_ptr_q].ep;
  assign count        = count_q;
  assign misalign     = misalign_q;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop  = fq.out_valid & fq.out_ready;
  assign push = ~redirect & ~stall & ((count_q < CW'(DEPTH)) | pop);

  // Next-state for pointers, occupancy, PC and epoch; redirect overrides all.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
`ifdef RVEE_PCGEN_RVC_EN
    misalign_d = 1'b0;
`else
    misalign_d = redirect & tgt_raw[1];
`endif
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_pc;
      epoch_d  = epoch_q + EPOCH_W'(1);
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + XLEN'(STEP);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state, including the EX redirect pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_q       <= resetv & ALIGN_MASK;
      epoch_q    <= '0;
      jmp_ff_q   <= 1'b0;
      base_q     <= '0;
      offset_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      jmp_ff_q   <= jmp;
      base_q     <= jmp_base;
      offset_q   <= jmp_offset;
      misalign_q <= misalign_d;
    end
  end

  // Queue storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: pc_q, ep: epoch_q};
  end
endmodule

// File: tb/tb_rvee_pcgen_fq.sv
// Self-checking bench for rvee_pcgen_fq: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_rvee_pcgen_fq;
  localparam int XLEN = 32, DEPTH = 4, STEP = 4, EPOCH_W = 2;
`ifdef RVEE_PCGEN_RVC_EN
  localparam logic [31:0] AMASK = 32'hFFFF_FFFE;
  localparam bit RVC = 1'b1;
`else
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
  localparam bit RVC = 1'b0;
`endif

  logic        clk, rst_n;
  logic [31:0] resetv, jmp_base, jmp_offset, trap_vec, redirect_pc;
  logic        jmp, bcc, trap, stall, redirect, misalign;
  logic [2:0]  count;

  rvee_pcgen_fq_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) fq ();

  rvee_pcgen_fq #(.XLEN(XLEN), .DEPTH(DEPTH), .STEP(STEP), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst_n(rst_n), .resetv(resetv),
    .jmp(jmp), .jmp_base(jmp_base), .jmp_offset(jmp_offset),
    .bcc(bcc), .trap(trap), .trap_vec(trap_vec), .stall(stall),
    .fq(fq), .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, epoch}, next PC, epoch, EX register stage.
  logic [XLEN+EPOCH_W-1:0] mq[$];
  logic [31:0]        m_pc, m_base, m_off;
  logic [EPOCH_W-1:0] m_ep;
  logic               m_jff, m_mis;
  logic               obs_red;
  logic [31:0]        obs_rpc;

  task automatic model_reset();
    mq.delete();
    m_pc = resetv & AMASK; m_ep = '0;
    m_jff = 1'b0; m_base = '0; m_off = '0; m_mis = 1'b0;
  endtask

  // Called at a falling edge: drive, check, advance model, wait next falling edge.
  task automatic step(input logic j, input logic [31:0] b, input logic [31:0] o,
                      input logic bc, input logic tr, input logic [31:0] tv,
                      input logic st, input logic rdy);
    logic br, red, v, pop, push;
    logic [31:0] raw, al;
    logic [XLEN+EPOCH_W-1:0] head;
    jmp = j; jmp_base = b; jmp_offset = o; bcc = bc; trap = tr; trap_vec = tv;
    stall = st; fq.out_ready = rdy;
    #1;
    br  = m_jff | bc;
    red = tr | br;
    raw = tr ? tv : (m_base + m_off);
    al  = raw & AMASK;
    v   = (mq.size() != 0);
    chk("out_valid", fq.out_valid, v);
    chk("count", count, mq.size());
    chk("redirect", redirect, red);
    chk("misalign", misalign, m_mis);
    if (red) chk("redirect_pc", redirect_pc, al);
    if (v) begin
      head = mq[0];
      chk("out_pc", fq.out_pc, head[EPOCH_W +: XLEN]);
      chk("out_epoch", fq.out_epoch, head[EPOCH_W-1:0]);
    end
    obs_red = redirect; obs_rpc = redirect_pc;
    pop  = v & rdy;
    push = !red && !st && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (red) begin
      mq.delete();
      m_pc = al;
      m_ep = m_ep + 1'b1;
    end else if (push) begin
      mq.push_back({m_pc, m_ep});
      m_pc = m_pc + STEP;
    end
    m_mis = RVC ? 1'b0 : (red & raw[1]);
    m_jff = j; m_base = b; m_off = o;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  // Asynchronous reset entered at a falling edge, released at the next one.
  task automatic do_reset(input logic [31:0] rv);
    rst_n = 1'b0; resetv = rv;
    #1;
    chk("rst_valid", fq.out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_misalign", misalign, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; resetv = 32'h1000;
    jmp = 0; jmp_base = 0; jmp_offset = 0; bcc = 0; trap = 0; trap_vec = 0;
    stall = 0; fq.out_ready = 1'b1;
    @(negedge clk);
    do_reset(32'h1000);

    // Sequential stream from the reset vector.
    idle(1'b1);
    chk("tp1_pc0", fq.out_pc, 32'h1000);
    idle(1'b1);
    chk("tp1_pc1", fq.out_pc, 32'h1004);
    idle(1'b1);
    chk("tp1_pc2", fq.out_pc, 32'h1008);
    chk("tp1_ep", fq.out_epoch, 0);

    // Backpressure fills the queue, then drains with no bubble.
    do_reset(32'h1000);
    repeat (6) idle(1'b0);
    chk("tp2_full", count, 4);
    chk("tp2_head", fq.out_pc, 32'h1000);
    repeat (4) idle(1'b1);
    chk("tp2_nobubble_v", fq.out_valid, 1'b1);
    chk("tp2_nobubble_pc", fq.out_pc, 32'h1010);

    // Jump redirect.
    step(1'b1, 32'h2000, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    chk("tp3_red", obs_red, 1'b1);
    chk("tp3_rpc", obs_rpc, 32'h2010);
    chk("tp3_flush", count, 0);
    idle(1'b1);
    chk("tp3_pc", fq.out_pc, 32'h2010);
    chk("tp3_ep", fq.out_epoch, 1);

    // Trap and branch together: trap wins, one epoch bump.
    step(1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
    chk("tp4_rpc", obs_rpc, 32'h80);
    idle(1'b1);
    chk("tp4_pc", fq.out_pc, 32'h80);
    chk("tp4_ep", fq.out_epoch, 2);

    // Target with bit1 set.
    step(1'b1, 32'h100, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    chk("tp5_misalign", misalign, RVC ? 1'b0 : 1'b1);
    idle(1'b1);
    chk("tp5_pc", fq.out_pc, RVC ? 32'h102 : 32'h100);

    // Reset while full, with a jump pending in the EX register.
    repeat (5) idle(1'b0);
    step(1'b1, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("tp6_full", count, 4);
    do_reset(32'h1000);
    idle(1'b1);
    chk("tp6_pc", fq.out_pc, 32'h1000);
    chk("tp6_ep", fq.out_epoch, 0);

    // Unaligned reset vector, then random traffic.
    do_reset(32'h4002);
    idle(1'b1);
    chk("rv_align", fq.out_pc, RVC ? 32'h4002 : 32'h4000);
    for (int i = 0; i < 600; i++) begin
      step($urandom % 8 == 0, $urandom, $urandom % 64,
           $urandom % 12 == 0, $urandom % 16 == 0, $urandom,
           $urandom % 5 == 0, $urandom % 10 < 7);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
